// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//   Eight-line prioritised interrupt controller feeding the microcode
//   sequencer. External IRQ lines are synchronised and rising-edge detected
//   into a pending register; a software-loaded mask selects which requests
//   may interrupt. A three-state FSM (IDLE/REQ/ACK) runs the request /
//   acknowledge handshake with the microcode.
//
// Parameters
//   VECTOR_BASE     base of the vector table; vector = base + 4*index (mod 256)
//
// Ports
//   clk             system clock, rising edge
//   arst_n          asynchronous active-low reset
//   irq_in[7:0]     async interrupt lines, rising-edge triggered, bit 0 highest
//   irq_en          global interrupt enable
//   mask_wrt        load mask from z_bus
//   z_bus[7:0]      mask load data
//   int_ack         level acknowledge from microcode
//   clear_all_ints  flush all pending requests and return to IDLE
//   int_pending     registered request to the sequencer (state == REQ)
//   int_vector[7:0] vector of the most recently acknowledged interrupt
//   pending[7:0]    raw pending register
//   mask[7:0]       current mask, 1 = enabled
// ---------------------------------------------------------------------------
module interrupt_controller #(
   parameter logic [7:0] VECTOR_BASE = 8'h00
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic [7:0] irq_in,
   input  logic       irq_en,
   input  logic       mask_wrt,
   input  logic [7:0] z_bus,
   input  logic       int_ack,
   input  logic       clear_all_ints,
   output logic       int_pending,
   output logic [7:0] int_vector,
   output logic [7:0] pending,
   output logic [7:0] mask
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   // synchroniser and edge history
   logic [7:0] r_s1;
   logic [7:0] r_s2;
   logic [7:0] r_prev;

   // architectural state
   logic [7:0] r_pending;
   logic [7:0] r_mask;
   logic [7:0] r_vector;
   logic       r_int_pending;
   state_t     r_state;

   // combinational
   logic [7:0] w_edge;
   logic [7:0] w_active;
   logic       w_any;
   logic       w_req_ok;
   logic [2:0] w_sel;
   logic       w_take;
   logic [7:0] w_clr_vec;
   logic [7:0] w_pend_nxt;
   logic [7:0] w_vec_nxt;
   logic       w_int_pending_nxt;
   state_t     w_state_nxt;

   assign w_edge   = r_s2 & ~r_prev;
   assign w_active = r_pending & r_mask;   // pre-write mask even on a mask_wrt cycle
   assign w_any    = |w_active;
   assign w_req_ok = irq_en & w_any;

   // lowest set index of active wins; scan high to low so the last hit sticks
   always_comb begin
      w_sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_active[i]) w_sel = i[2:0];
      end
   end

   // An ack is only honoured with something to grant; clear_all overrides it.
   assign w_take    = (r_state == S_REQ) & int_ack & w_any & ~clear_all_ints;
   assign w_clr_vec = w_take ? (8'b0000_0001 << w_sel) : 8'h00;

   // New edges are OR'd in after the clear so a set on the acked bit survives.
   assign w_pend_nxt = clear_all_ints ? 8'h00 : ((r_pending & ~w_clr_vec) | w_edge);

   // ------------------------------------------------------------------
   // synchroniser
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_s1   <= 8'h00;
         r_s2   <= 8'h00;
         r_prev <= 8'h00;
      end else begin
         r_s1   <= irq_in;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   // ------------------------------------------------------------------
   // pending / mask / vector
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_pending <= 8'h00;
         r_mask    <= 8'h00;
         r_vector  <= VECTOR_BASE;
      end else begin
         r_pending <= w_pend_nxt;
         if (mask_wrt) r_mask <= z_bus;
         if (w_take)   r_vector <= w_vec_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state       <= S_IDLE;
         r_int_pending <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_int_pending <= w_int_pending_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_req_ok) w_state_nxt = S_REQ;
         S_REQ: begin
            if (w_take)         w_state_nxt = S_ACK;
            else if (!w_req_ok) w_state_nxt = S_IDLE;  // request withdrawn
         end
         S_ACK:  if (!int_ack) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear_all_ints) w_state_nxt = S_IDLE;
   end

   // ------------------------------------------------------------------
   // FSM: outputs (next-cycle values of the registered outputs)
   // ------------------------------------------------------------------
   always_comb begin
      w_int_pending_nxt = (w_state_nxt == S_REQ);
      w_vec_nxt         = VECTOR_BASE + {3'b000, w_sel, 2'b00};
   end

   assign int_pending = r_int_pending;
   assign int_vector  = r_vector;
   assign pending     = r_pending;
   assign mask        = r_mask;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//   Directed bench for interrupt_controller (VECTOR_BASE = 0). Inputs are
//   driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

   logic       clk;
   logic       arst_n;
   logic [7:0] irq_in;
   logic       irq_en;
   logic       mask_wrt;
   logic [7:0] z_bus;
   logic       int_ack;
   logic       clear_all_ints;
   logic       int_pending;
   logic [7:0] int_vector;
   logic [7:0] pending;
   logic [7:0] mask;

   int n_chk;
   int n_fail;

   interrupt_controller #(.VECTOR_BASE(8'h00)) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .irq_in         (irq_in),
      .irq_en         (irq_en),
      .mask_wrt       (mask_wrt),
      .z_bus          (z_bus),
      .int_ack        (int_ack),
      .clear_all_ints (clear_all_ints),
      .int_pending    (int_pending),
      .int_vector     (int_vector),
      .pending        (pending),
      .mask           (mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // advance n rising edges, land 1 ns after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_mask(input logic [7:0] m);
      mask_wrt = 1'b1;
      z_bus    = m;
      tick(1);
      mask_wrt = 1'b0;
   endtask

   initial begin
      n_chk          = 0;
      n_fail         = 0;
      arst_n         = 1'b0;
      irq_in         = 8'h00;
      irq_en         = 1'b0;
      mask_wrt       = 1'b0;
      z_bus          = 8'h00;
      int_ack        = 1'b0;
      clear_all_ints = 1'b0;

      // ---------------- reset state ----------------
      tick(3);
      chk("rst_pending", {24'd0, pending}, 32'h00);
      chk("rst_mask",    {24'd0, mask}, 32'h00);
      chk("rst_vector",  {24'd0, int_vector}, 32'h00);
      chk("rst_intpend", {31'd0, int_pending}, 32'd0);
      arst_n = 1'b1;
      tick(2);

      // ---------------- basic flow ----------------
      wr_mask(8'h08);
      chk("basic_mask", {24'd0, mask}, 32'h08);
      irq_en = 1'b1;
      irq_in = 8'h08;
      tick(1);                                  // E0
      chk("basic_e0_ip", {31'd0, int_pending}, 32'd0);
      tick(1);                                  // E1
      irq_in = 8'h00;
      tick(1);                                  // E2
      chk("basic_e2_pend", {24'd0, pending}, 32'h08);
      chk("basic_e2_ip", {31'd0, int_pending}, 32'd0);
      tick(1);                                  // E3
      chk("basic_e3_ip", {31'd0, int_pending}, 32'd1);
      int_ack = 1'b1;
      tick(1);                                  // ack edge
      chk("basic_vec", {24'd0, int_vector}, 32'h0C);
      chk("basic_pend0", {24'd0, pending}, 32'h00);
      chk("basic_ip_low", {31'd0, int_pending}, 32'd0);
      tick(1);                                  // still acking
      chk("basic_ack_hold", {31'd0, int_pending}, 32'd0);
      int_ack = 1'b0;
      tick(2);
      chk("basic_idle", {31'd0, int_pending}, 32'd0);

      // ---------------- priority ----------------
      wr_mask(8'hFF);
      irq_in = 8'h24;
      tick(2);
      irq_in = 8'h00;
      tick(1);
      chk("prio_pend", {24'd0, pending}, 32'h24);
      tick(1);
      chk("prio_req", {31'd0, int_pending}, 32'd1);
      int_ack = 1'b1;
      tick(1);
      chk("prio_vec1", {24'd0, int_vector}, 32'h08);
      chk("prio_pend1", {24'd0, pending}, 32'h20);
      int_ack = 1'b0;
      tick(1);                                  // B: IDLE
      chk("prio_idle", {31'd0, int_pending}, 32'd0);
      tick(1);                                  // B+1: re-request
      chk("prio_rereq", {31'd0, int_pending}, 32'd1);
      int_ack = 1'b1;
      tick(1);
      chk("prio_vec2", {24'd0, int_vector}, 32'h14);
      chk("prio_pend2", {24'd0, pending}, 32'h00);
      int_ack = 1'b0;
      tick(2);

      // ---------------- masking and enable ----------------
      wr_mask(8'h00);
      irq_in = 8'h01;
      tick(2);
      irq_in = 8'h00;
      tick(1);
      chk("mask_pend", {24'd0, pending}, 32'h01);
      chk("mask_noreq_a", {31'd0, int_pending}, 32'd0);
      tick(2);
      chk("mask_noreq_b", {31'd0, int_pending}, 32'd0);
      wr_mask(8'h01);                           // write edge W
      chk("mask_w0", {31'd0, int_pending}, 32'd0);
      tick(1);                                  // W+1
      chk("mask_w1", {31'd0, int_pending}, 32'd1);
      irq_en = 1'b0;
      tick(1);
      chk("en_drop_ip", {31'd0, int_pending}, 32'd0);
      chk("en_drop_pend", {24'd0, pending}, 32'h01);
      tick(1);
      chk("en_off_stay", {31'd0, int_pending}, 32'd0);

      // ---------------- clear all ----------------
      irq_en = 1'b1;
      wr_mask(8'hFF);
      irq_in = 8'h0E;
      tick(2);
      irq_in = 8'h00;
      tick(1);
      chk("clr_pend_pre", {24'd0, pending}, 32'h0F);
      tick(1);
      chk("clr_req", {31'd0, int_pending}, 32'd1);
      irq_in = 8'h80;
      tick(2);                                  // edge[7] live this cycle
      clear_all_ints = 1'b1;
      tick(1);
      clear_all_ints = 1'b0;
      chk("clr_pend", {24'd0, pending}, 32'h00);
      chk("clr_ip", {31'd0, int_pending}, 32'd0);
      chk("clr_vec_kept", {24'd0, int_vector}, 32'h14);
      chk("clr_mask_kept", {24'd0, mask}, 32'hFF);
      tick(2);
      chk("clr_edge_drop", {24'd0, pending}, 32'h00);
      chk("clr_stay_idle", {31'd0, int_pending}, 32'd0);
      irq_in = 8'h00;
      tick(3);

      // ---------------- set/clear collision ----------------
      irq_in = 8'h10;
      tick(2);
      tick(1);                                  // E2
      chk("coll_pend", {24'd0, pending}, 32'h10);
      tick(1);                                  // E3
      chk("coll_req", {31'd0, int_pending}, 32'd1);
      irq_in = 8'h00;
      tick(2);
      irq_in = 8'h10;
      tick(2);                                  // second edge live now
      int_ack = 1'b1;
      tick(1);
      chk("coll_vec", {24'd0, int_vector}, 32'h10);
      chk("coll_pend_kept", {24'd0, pending}, 32'h10);
      chk("coll_ip_low", {31'd0, int_pending}, 32'd0);
      int_ack = 1'b0;
      tick(1);
      chk("coll_idle", {31'd0, int_pending}, 32'd0);
      tick(1);
      chk("coll_rereq", {31'd0, int_pending}, 32'd1);
      int_ack = 1'b1;
      tick(1);                                  // now in ACK, line 4 still high
      chk("coll_pend_clr", {24'd0, pending}, 32'h00);

      // ---------------- reset in ACK ----------------
      #2;
      arst_n = 1'b0;
      #1;
      chk("arst_pend", {24'd0, pending}, 32'h00);
      chk("arst_mask", {24'd0, mask}, 32'h00);
      chk("arst_vec", {24'd0, int_vector}, 32'h00);
      chk("arst_ip", {31'd0, int_pending}, 32'd0);
      int_ack = 1'b0;
      @(posedge clk);
      #3;
      arst_n = 1'b1;
      tick(3);                                  // held line: s1, s2, pending
      chk("held_pend", {24'd0, pending}, 32'h10);
      chk("held_masked", {31'd0, int_pending}, 32'd0);
      wr_mask(8'h10);
      tick(1);
      chk("held_req", {31'd0, int_pending}, 32'd1);
      int_ack = 1'b1;
      tick(1);
      chk("held_vec", {24'd0, int_vector}, 32'h10);
      int_ack = 1'b0;
      tick(3);
      chk("held_once", {31'd0, int_pending}, 32'd0);
      chk("held_pend0", {24'd0, pending}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
